button_conditioner: RTL and testbench

Input-conditioning stage directly upstream of the tank/block movement controller. Takes raw, asynchronous, bouncing push-button levels (left, right, fire) from the board and produces clean, synchronous control signals: mutually exclusive movement levels and a rate-limited single-cycle fire pulse. All outputs are registered on the single system clock and feed the movement and projectile logic unchanged.

---
 rtl/button_conditioner.sv | 143 ++++++++++++++
 tb/tb_button_conditioner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Conditions raw board buttons: 2-flop synchronizer, per-button debounce FSM,
// left/right arbitration and a cooldown-limited single-cycle fire strobe.
module button_conditioner #(
    parameter int DB_CYCLES       = 1_000_000,
    parameter int DB_W            = 20,
    parameter int COOLDOWN_CYCLES = 25_000_000,
    parameter int CD_W            = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_fire,
    output logic left,
    output logic right,
    output logic fire_pulse,
    output logic fire_ready
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES);

    logic [2:0] btn_raw;
    logic [2:0] db;
    logic       db_left;
    logic       db_right;
    logic       db_fire;
    logic       db_fire_p1;
    logic       fire_rise;
    logic [CD_W-1:0] cooldown;

    assign btn_raw = {btn_fire, btn_right, btn_left};

    for (genvar i = 0; i < 3; i++) begin : g_db
        typedef enum logic [1:0] {IDLE, ARM, PRESSED, RELEASE} db_state_t;

        db_state_t       state;
        db_state_t       state_nxt;
        logic [DB_W-1:0] cnt;
        logic [DB_W-1:0] cnt_nxt;
        logic            sync_p0;
        logic            sync_p1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_p0 <= 1'b0;
                sync_p1 <= 1'b0;
                state   <= IDLE;
                cnt     <= '0;
            end else begin
                sync_p0 <= btn_raw[i];
                sync_p1 <= sync_p0;
                state   <= state_nxt;
                cnt     <= cnt_nxt;
            end
        end

        // Any disagreement with the candidate level restarts qualification.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            unique case (state)
                IDLE: begin
                    if (sync_p1) begin
                        state_nxt = ARM;
                        cnt_nxt   = DB_W'(1);
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                ARM: begin
                    if (!sync_p1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt >= DB_LAST) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + DB_W'(1);
                    end
                end
                PRESSED: begin
                    if (!sync_p1) begin
                        state_nxt = RELEASE;
                        cnt_nxt   = DB_W'(1);
                    end
                end
                RELEASE: begin
                    if (sync_p1) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt >= DB_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + DB_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign db[i] = (state == PRESSED) || (state == RELEASE);
    end

    assign db_left   = db[0];
    assign db_right  = db[1];
    assign db_fire   = db[2];
    assign fire_rise = db_fire & ~db_fire_p1;

    // Output stage: arbitration and fire rate limiting share one register edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left       <= 1'b0;
            right      <= 1'b0;
            db_fire_p1 <= 1'b0;
            fire_pulse <= 1'b0;
            cooldown   <= '0;
            fire_ready <= 1'b1;
        end else begin
            left       <= db_left & ~db_right;
            right      <= db_right & ~db_left;
            db_fire_p1 <= db_fire;
            if (fire_rise && (cooldown == '0)) begin
                fire_pulse <= 1'b1;
                cooldown   <= CD_LOAD;
                fire_ready <= 1'b0;
            end else begin
                fire_pulse <= 1'b0;
                if (cooldown != '0) begin
                    cooldown   <= cooldown - CD_W'(1);
                    fire_ready <= (cooldown == CD_W'(1));
                end else begin
                    fire_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized bench for button_conditioner against a stable-run
// reference model of synchronizer, debounce, arbitration and fire cooldown.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int CD = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;
    logic btn_fire = 1'b0;
    logic left;
    logic right;
    logic fire_pulse;
    logic fire_ready;

    int vectors = 0;
    int miscompares = 0;
    int pulse_cnt = 0;
    int ready_low_cnt = 0;
    int n;

    // Reference model state
    logic [2:0] m_s1, m_s2, m_db;
    int         m_run [3];
    logic       m_dbf_prev;
    int         m_cd;
    logic       m_left, m_right, m_pulse, m_ready;

    always #5 clk = ~clk;

    button_conditioner #(
        .DB_CYCLES      (DB),
        .DB_W           (3),
        .COOLDOWN_CYCLES(CD),
        .CD_W           (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_fire  (btn_fire),
        .left      (left),
        .right     (right),
        .fire_pulse(fire_pulse),
        .fire_ready(fire_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        m_db = '0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        m_dbf_prev = 1'b0;
        m_cd = 0;
        m_left = 1'b0;
        m_right = 1'b0;
        m_pulse = 1'b0;
        m_ready = 1'b1;
    endtask

    // A level is accepted once the synchronized input has disagreed with it
    // for DB consecutive edges; outputs follow the accepted levels one edge later.
    task automatic model_edge(input logic [2:0] raw);
        m_left  = m_db[0] & ~m_db[1];
        m_right = m_db[1] & ~m_db[0];
        if (m_db[2] && !m_dbf_prev && m_cd == 0) begin
            m_pulse = 1'b1;
            m_cd = CD;
        end else begin
            m_pulse = 1'b0;
            if (m_cd > 0) m_cd--;
        end
        m_ready = (m_cd == 0);
        m_dbf_prev = m_db[2];
        for (int i = 0; i < 3; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_db[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic step();
        logic [2:0] raw;
        raw = {btn_fire, btn_right, btn_left};
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(raw);
        #1;
        chk("left", left, m_left);
        chk("right", right, m_right);
        chk("fire_pulse", fire_pulse, m_pulse);
        chk("fire_ready", fire_ready, m_ready);
        chk("exclusive", left & right, 1'b0);
        pulse_cnt += int'(fire_pulse);
        ready_low_cnt += int'(!fire_ready);
    endtask

    task automatic hold(input logic [2:0] b, input int cycles);
        {btn_fire, btn_right, btn_left} = b;
        repeat (cycles) step();
    endtask

    task automatic wait_for(input bit sel_right, input logic val, output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while (((sel_right ? right : left) !== val) && edges < 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();

        // Reset state
        hold(3'b000, 2);
        chk("rst_fire_ready", fire_ready, 1'b1);
        rst_n = 1'b1;
        hold(3'b000, 3);

        // Clean press and release of left
        btn_left = 1'b1;
        wait_for(1'b0, 1'b1, n);
        chk("left_rise_latency", n, 7);
        hold(3'b001, 20 - n);
        btn_left = 1'b0;
        wait_for(1'b0, 1'b0, n);
        chk("left_fall_latency", n, 7);
        hold(3'b000, 5);

        // Bouncing right, then held
        hold(3'b010, 2);
        hold(3'b000, 2);
        hold(3'b010, 2);
        hold(3'b000, 2);
        btn_right = 1'b1;
        wait_for(1'b1, 1'b1, n);
        chk("right_rise_after_bounce", n, 7);
        hold(3'b000, 10);

        // Both held: neither direction, left returns after right releases
        hold(3'b001, 12);
        chk("left_alone", left, 1'b1);
        hold(3'b011, 12);
        chk("both_left", left, 1'b0);
        chk("both_right", right, 1'b0);
        btn_right = 1'b0;
        wait_for(1'b0, 1'b1, n);
        chk("left_return_latency", n, 7);
        hold(3'b000, 10);

        // Fire held: one pulse, ready low for exactly the cooldown
        pulse_cnt = 0;
        ready_low_cnt = 0;
        hold(3'b100, 30);
        chk("fire_hold_pulses", pulse_cnt, 1);
        chk("fire_ready_low_cycles", ready_low_cnt, CD);
        hold(3'b000, 12);

        // Re-press lands inside cooldown and is discarded
        pulse_cnt = 0;
        hold(3'b100, 4);
        hold(3'b000, 5);
        hold(3'b100, 20);
        chk("fire_cooldown_discard", pulse_cnt, 1);
        hold(3'b000, 12);

        // Re-press after ready
        pulse_cnt = 0;
        hold(3'b100, 10);
        chk("fire_after_ready", pulse_cnt, 1);
        hold(3'b000, 12);

        // Asynchronous reset mid-cooldown with left qualified
        hold(3'b101, 11);
        chk("pre_reset_left", left, 1'b1);
        chk("pre_reset_ready", fire_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_left", left, 1'b0);
        chk("async_rst_ready", fire_ready, 1'b1);
        chk("async_rst_pulse", fire_pulse, 1'b0);
        model_reset();
        hold(3'b101, 2);
        rst_n = 1'b1;
        wait_for(1'b0, 1'b1, n);
        chk("left_requalify_latency", n, 7);
        hold(3'b000, 12);

        // Randomized segments against the model
        repeat (80) begin
            logic [2:0] b;
            b = 3'($urandom);
            hold(b, int'($urandom_range(1, 8)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
